// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator and its checker.
// Both ends take the taps and the feedback function from here so they stay in step.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int FILL_W = $clog2(LFSR_W + 1);

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  function automatic logic lfsr16_fb(input logic [LFSR_W-1:0] shadow);
    return shadow[TAP_A] ^ shadow[TAP_B] ^ shadow[TAP_C] ^ shadow[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr16_shadow.sv
// Shadow copy of the remote generator. Shifts in either the received bit or
// its own prediction (flywheel) and exposes the prediction and next value.
module lfsr16_shadow
  import lfsr_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic              sel_pred_i,
  input  logic              bit_i,
  output logic              pred_o,
  output logic [LFSR_W-1:0] shadow_nxt_o
);

  logic [LFSR_W-1:0] shadow_q;

  assign pred_o       = lfsr16_fb(shadow_q);
  assign shadow_nxt_o = {shadow_q[LFSR_W-2:0], (sel_pred_i ? pred_o : bit_i)};

  // Shift register update, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_q <= '0;
    end else if (shift_en_i) begin
      shadow_q <= shadow_nxt_o;
    end
  end

endmodule

// File: rtl/lfsr16_seq_checker.sv
// Receive-side LFSR sequence checker: seeds a shadow LFSR from the incoming
// stream, verifies predictions before declaring lock, then counts bit errors.
//
// state  | meaning
// SEED   | loading 16 received bits into the shadow register
// VERIFY | counting consecutive correct predictions toward lock
// LOCKED | tracking the stream, counting mispredictions as errors
module lfsr16_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_seq,
  output logic [1:0]       state
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_THRESH - 1);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_W - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = '1;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]  miss_run_q, miss_run_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               zero_seq_q, zero_seq_d;

  logic              pred;
  logic              match;
  logic              shift_en;
  logic              sel_pred;
  logic [LFSR_W-1:0] shadow_nxt;

  assign match = (bit_in == pred);

  // Shadow advances on every valid bit except a VERIFY mismatch, which reseeds anyway.
  assign shift_en = bit_valid &&
                    ((state_q == ST_SEED) || (state_q == ST_LOCKED) ||
                     ((state_q == ST_VERIFY) && match));
  // In LOCKED a bad bit is replaced by the prediction so one error does not corrupt the shadow.
  assign sel_pred = bit_valid && (state_q == ST_LOCKED) && !match;

  lfsr16_shadow u_shadow (
    .clock        (clock),
    .reset        (reset),
    .shift_en_i   (shift_en),
    .sel_pred_i   (sel_pred),
    .bit_i        (bit_in),
    .pred_o       (pred),
    .shadow_nxt_o (shadow_nxt)
  );

  // Next-state and next-output decode for the sequencing FSM and counters.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    miss_run_d  = miss_run_q;
    locked_d    = locked_q;
    zero_seq_d  = zero_seq_q;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      case (state_q)
        ST_SEED: begin
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            if (shadow_nxt == '0) begin
              zero_seq_d = 1'b1;
            end else begin
              zero_seq_d  = 1'b0;
              state_d     = ST_VERIFY;
              match_cnt_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q == MATCH_LAST) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              miss_run_d = '0;
            end
          end else begin
            state_d = ST_SEED;
            fill_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            miss_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            miss_run_d  = miss_run_q + 1'b1;
            if (miss_run_q == MISS_LAST) begin
              state_d  = ST_SEED;
              locked_d = 1'b0;
              fill_d   = '0;
            end
          end
        end
        default: begin
          state_d  = ST_SEED;
          locked_d = 1'b0;
          fill_d   = '0;
        end
      endcase
    end

    // A clear coincident with an error keeps that error.
    if (clear_err) begin
      err_count_d = err_pulse_d ? ERR_W'(1) : '0;
    end else if (err_pulse_d && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Register all FSM state and outputs; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_SEED;
      fill_q      <= '0;
      match_cnt_q <= '0;
      miss_run_q  <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      zero_seq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      miss_run_q  <= miss_run_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      zero_seq_q  <= zero_seq_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign zero_seq  = zero_seq_q;

endmodule

// File: tb/tb_lfsr16_seq_checker.sv
// Directed bench for lfsr16_seq_checker with an independent generator model.
module tb_lfsr16_seq_checker;

  // Narrow error counter so saturation is reachable in a short run.
  localparam int TB_ERR_W = 10;
  localparam logic [TB_ERR_W-1:0] ERR_ALL = 10'h3FF;

  logic                clock;
  logic                reset;
  logic                bit_valid;
  logic                bit_in;
  logic                clear_err;
  logic                locked;
  logic                err_pulse;
  logic [TB_ERR_W-1:0] err_count;
  logic                zero_seq;
  logic [1:0]          state;

  int n_checks;
  int n_fail;
  logic [15:0] g;

  lfsr16_seq_checker #(
    .LOCK_COUNT  (32),
    .LOSS_THRESH (4),
    .ERR_W       (TB_ERR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .zero_seq  (zero_seq),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic gen_next(output logic b);
    logic fb;
    fb = g[15] ^ g[13] ^ g[12] ^ g[10];
    g  = {g[14:0], fb};
    b  = fb;
  endtask

  task automatic send(input logic b, input logic clr);
    @(negedge clock);
    bit_valid = 1'b1;
    bit_in    = b;
    clear_err = clr;
    @(posedge clock);
    #1;
    bit_valid = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic idle(input logic clr);
    @(negedge clock);
    bit_valid = 1'b0;
    bit_in    = 1'($urandom);
    clear_err = clr;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic send_gen(input logic flip, input logic clr);
    logic b;
    gen_next(b);
    send(b ^ flip, clr);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset     = 1'b0;
    bit_valid = 1'b0;
    clear_err = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      clear_err = 1'($urandom);
      @(posedge clock);
      #1;
      @(negedge clock);
    end
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b exp 00", state); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_checks++;
    if (err_count !== '0) begin n_fail++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    n_checks++;
    if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
    n_checks++;
    if (zero_seq !== 1'b0) begin n_fail++; $display("FAIL reset_zero_seq got %b exp 0", zero_seq); end
    reset     = 1'b1;
    bit_valid = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic test_clean_lock();
    apply_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 48; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 15) begin
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL lock_state_bit15 got %b exp 00", state); end
      end
      if (i == 16) begin
        n_checks++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL lock_state_bit16 got %b exp 01", state); end
      end
      if (i == 47) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early_bit47 got %b exp 0", locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_bit48 got %b exp 1", locked); end
    n_checks++;
    if (state !== 2'b10) begin n_fail++; $display("FAIL lock_state_bit48 got %b exp 10", state); end
    n_checks++;
    if (err_count !== '0) begin n_fail++; $display("FAIL lock_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_single_error();
    int pulses;
    send_gen(1'b1, 1'b0);
    n_checks++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse got %b exp 1", err_pulse); end
    n_checks++;
    if (err_count !== 10'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", err_count); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked got %b exp 1", locked); end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      send_gen(1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL single_followup_pulses got %0d exp 0", pulses); end
    n_checks++;
    if (err_count !== 10'd1) begin n_fail++; $display("FAIL single_followup_count got %0d exp 1", err_count); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL single_followup_locked got %b exp 1", locked); end
  endtask

  task automatic test_loss_relock();
    idle(1'b1);
    n_checks++;
    if (err_count !== '0) begin n_fail++; $display("FAIL clear_idle got %0d exp 0", err_count); end
    for (int i = 1; i <= 4; i++) begin
      send_gen(1'b1, 1'b0);
      n_checks++;
      if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL loss_pulse_%0d got %b exp 1", i, err_pulse); end
      if (i == 3) begin
        n_checks++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early_bit3 got %b exp 1", locked); end
      end
    end
    n_checks++;
    if (err_count !== 10'd4) begin n_fail++; $display("FAIL loss_count got %0d exp 4", err_count); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked got %b exp 0", locked); end
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL loss_state got %b exp 00", state); end
    for (int i = 1; i <= 48; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 47) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early got %b exp 0", locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL relock got %b exp 1", locked); end
    n_checks++;
    if (err_count !== 10'd4) begin n_fail++; $display("FAIL relock_count got %0d exp 4", err_count); end
  endtask

  task automatic test_counter_edges();
    int n;
    idle(1'b1);
    n = 0;
    while (n < 1023) begin
      for (int k = 0; k < 3 && n < 1023; k++) begin
        send_gen(1'b1, 1'b0);
        n++;
      end
      send_gen(1'b0, 1'b0);
    end
    n_checks++;
    if (err_count !== ERR_ALL) begin n_fail++; $display("FAIL sat_preload got %0d exp 1023", err_count); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked got %b exp 1", locked); end
    send_gen(1'b1, 1'b0);
    n_checks++;
    if (err_count !== ERR_ALL) begin n_fail++; $display("FAIL sat_hold got %0d exp 1023", err_count); end
    n_checks++;
    if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got %b exp 1", err_pulse); end
    send_gen(1'b0, 1'b0);
    send_gen(1'b1, 1'b1);
    n_checks++;
    if (err_count !== 10'd1) begin n_fail++; $display("FAIL clear_coincident got %0d exp 1", err_count); end
    send_gen(1'b0, 1'b0);
  endtask

  task automatic test_zero_seq();
    apply_reset();
    for (int i = 0; i < 16; i++) send(1'b0, 1'b0);
    n_checks++;
    if (zero_seq !== 1'b1) begin n_fail++; $display("FAIL zero_seq_set got %b exp 1", zero_seq); end
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL zero_seq_state got %b exp 00", state); end
    g = 16'h1234;
    for (int i = 1; i <= 48; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 16) begin
        n_checks++;
        if (zero_seq !== 1'b0) begin n_fail++; $display("FAIL zero_seq_clear got %b exp 0", zero_seq); end
        n_checks++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL zero_seq_verify got %b exp 01", state); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL zero_seq_lock got %b exp 1", locked); end
  endtask

  task automatic test_gaps();
    int gap;
    apply_reset();
    g = 16'hACE1;
    for (int i = 1; i <= 48; i++) begin
      gap = (i == 17 || i == 48) ? 2 : $urandom_range(3, 0);
      repeat (gap) idle(1'b0);
      if (i == 17 || i == 48) begin
        n_checks++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL gap_hold_state bit %0d got %b exp 01", i, state); end
        n_checks++;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL gap_err_pulse got %b exp 0", err_pulse); end
      end
      send_gen(1'b0, 1'b0);
      if (i == 47) begin
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_early got %b exp 0", locked); end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_lock got %b exp 1", locked); end
    send_gen(1'b1, 1'b0);
    n_checks++;
    if (err_count !== 10'd1) begin n_fail++; $display("FAIL gap_err got %0d exp 1", err_count); end
    // Reset while locked and fed a valid bit must still win.
    @(negedge clock);
    reset     = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (locked !== 1'b0 || state !== 2'b00 || err_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_lock got locked=%b state=%b err=%0d exp 0/00/0", locked, state, err_count);
    end
    @(negedge clock);
    reset     = 1'b1;
    bit_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear_err = 1'b0;
    g         = 16'hACE1;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_relock();
    test_counter_edges();
    test_zero_seq();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
